// File: rtl/keyevt_pkg.sv
// -----------------------------------------------------------------------------
// keyevt_pkg
// Shared definitions for the keycode event decoder:
//   KEY_NONE     - code value marking an empty keycode slot
//   SLOTS        - number of 8-bit slots in a keycode word
//   key_event_t  - queued event {code, press}
//   dec_state_t  - decoder FSM states
//   count_distinct() - number of distinct non-empty codes in a keycode word
// -----------------------------------------------------------------------------
package keyevt_pkg;

    localparam logic [7:0] KEY_NONE = 8'h00;
    localparam int         SLOTS    = 4;

    typedef struct packed {
        logic [7:0] code;
        logic       press;
    } key_event_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN_REL,
        ST_SCAN_PRS,
        ST_COMMIT
    } dec_state_t;

    // A slot counts only if it is non-empty and no lower slot holds the same
    // code, so duplicated codes are counted once.
    function automatic logic [2:0] count_distinct(input logic [31:0] word);
        logic [2:0] cnt;
        logic       dup;
        cnt = 3'd0;
        for (int i = 0; i < SLOTS; i++) begin
            dup = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (word[j*8 +: 8] == word[i*8 +: 8]) begin
                    dup = 1'b1;
                end
            end
            if (word[i*8 +: 8] != KEY_NONE && !dup) begin
                cnt = cnt + 3'd1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// pop_data_o whenever empty_o is low; pop_data_o reads as zero when empty.
// A push on a full FIFO is accepted when a pop happens in the same cycle.
// A pop on an empty FIFO is ignored.
// Ports:
//   clk, srst           - clock, synchronous active-high reset
//   push_i, push_data_i - write request and data
//   pop_i               - consumer takes the head entry
//   pop_data_o          - head entry
//   full_o, empty_o     - occupancy flags
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // One extra pointer bit distinguishes full from empty when indices match.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/keycode_event_decoder.sv
// -----------------------------------------------------------------------------
// keycode_event_decoder
// Turns the 4-slot keycode word from the MicroBlaze GPIO into a stream of
// press/release events. A word is accepted once it has been stable for
// STABLE_CYCLES cycles and differs from the committed snapshot; the FSM then
// scans old slots for releases, new slots for presses, and commits the word.
// Ports:
//   Clk, reset_ah           - clock, synchronous active-high reset
//   keycode                 - four 8-bit slots, slot0 = [7:0], 8'h00 = empty
//   evt_valid / evt_ready   - FWFT event handshake
//   evt_code, evt_press     - head event (press=1, release=0)
//   busy                    - scan/commit in progress
//   held_count              - distinct keys in committed snapshot
// -----------------------------------------------------------------------------
module keycode_event_decoder
    import keyevt_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic        Clk,
    input  logic        reset_ah,
    input  logic [31:0] keycode,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [7:0]  evt_code,
    output logic        evt_press,
    output logic        busy,
    output logic [2:0]  held_count
);

    localparam int             CW         = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  STABLE_MAX = CW'(STABLE_CYCLES);

    logic [31:0]   keycode_q;
    logic [CW-1:0] stable_cnt_q;
    dec_state_t    state_q, state_d;
    logic [1:0]    slot_q, slot_d;
    logic [31:0]   latched_q, latched_d;
    logic [31:0]   snapshot_q, snapshot_d;
    logic [2:0]    held_count_q, held_count_d;

    logic          word_new;
    logic [7:0]    old_code;
    logic [7:0]    new_code;
    logic [SLOTS-1:0] old_in_new, old_dup, new_in_old, new_dup;
    logic          rel_hit, prs_hit;

    logic          fifo_push;
    key_event_t    fifo_push_evt;
    key_event_t    fifo_head;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_can_take;

    // Input sampling and stability counter.
    always_ff @(posedge Clk) begin
        if (reset_ah) begin
            keycode_q    <= '0;
            stable_cnt_q <= '0;
        end else begin
            keycode_q <= keycode;
            if (keycode != keycode_q) begin
                stable_cnt_q <= '0;
            end else if (stable_cnt_q != STABLE_MAX) begin
                stable_cnt_q <= stable_cnt_q + CW'(1);
            end
        end
    end

    assign word_new = (stable_cnt_q == STABLE_MAX) && (state_q == ST_IDLE) &&
                      (keycode_q != snapshot_q);

    assign old_code = snapshot_q[{slot_q, 3'b000} +: 8];
    assign new_code = latched_q[{slot_q, 3'b000} +: 8];

    // Per-slot comparisons against the slot currently being scanned.
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot_cmp
        assign old_in_new[gi] = (latched_q[gi*8 +: 8] == old_code);
        assign new_in_old[gi] = (snapshot_q[gi*8 +: 8] == new_code);
        assign old_dup[gi]    = (snapshot_q[gi*8 +: 8] == old_code) && (2'(gi) < slot_q);
        assign new_dup[gi]    = (latched_q[gi*8 +: 8] == new_code) && (2'(gi) < slot_q);
    end

    assign rel_hit = (old_code != KEY_NONE) && !(|old_in_new) && !(|old_dup);
    assign prs_hit = (new_code != KEY_NONE) && !(|new_in_old) && !(|new_dup);

    // A full FIFO still takes a push when the consumer pops in the same cycle.
    assign fifo_pop      = evt_valid && evt_ready;
    assign fifo_can_take = !fifo_full || fifo_pop;

    always_ff @(posedge Clk) begin
        if (reset_ah) begin
            state_q      <= ST_IDLE;
            slot_q       <= '0;
            latched_q    <= '0;
            snapshot_q   <= '0;
            held_count_q <= '0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            latched_q    <= latched_d;
            snapshot_q   <= snapshot_d;
            held_count_q <= held_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        latched_d     = latched_q;
        snapshot_d    = snapshot_q;
        held_count_d  = held_count_q;
        fifo_push     = 1'b0;
        fifo_push_evt = '0;

        case (state_q)
            ST_IDLE: begin
                if (word_new) begin
                    latched_d = keycode_q;
                    slot_d    = '0;
                    state_d   = ST_SCAN_REL;
                end
            end
            ST_SCAN_REL: begin
                fifo_push_evt = '{code: old_code, press: 1'b0};
                fifo_push     = rel_hit;
                // Hold the slot index while an event waits for FIFO space.
                if (!rel_hit || fifo_can_take) begin
                    if (slot_q == 2'd3) begin
                        slot_d  = '0;
                        state_d = ST_SCAN_PRS;
                    end else begin
                        slot_d = slot_q + 2'd1;
                    end
                end
            end
            ST_SCAN_PRS: begin
                fifo_push_evt = '{code: new_code, press: 1'b1};
                fifo_push     = prs_hit;
                if (!prs_hit || fifo_can_take) begin
                    if (slot_q == 2'd3) begin
                        slot_d  = '0;
                        state_d = ST_COMMIT;
                    end else begin
                        slot_d = slot_q + 2'd1;
                    end
                end
            end
            ST_COMMIT: begin
                snapshot_d   = latched_q;
                held_count_d = count_distinct(latched_q);
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    sync_fifo #(
        .WIDTH ($bits(key_event_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk         (Clk),
        .srst        (reset_ah),
        .push_i      (fifo_push),
        .push_data_i (fifo_push_evt),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign evt_valid  = !fifo_empty;
    assign evt_code   = fifo_head.code;
    assign evt_press  = fifo_head.press;
    assign busy       = (state_q != ST_IDLE);
    assign held_count = held_count_q;

endmodule
